key_debounce: RTL and testbench

- Input-conditioning stage that sits directly upstream of the loadable BCD counter.
- Synchronizes and debounces the raw board inputs: the load button, the type switch and the 4 data switches.
- Outputs clean levels plus single-cycle press/release strobes in the clk domain, so the counter never sees metastable or bouncing inputs.
- One debounce engine per input bit; all bits are identical and independent.

---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_cell.sv | 100 ++++++++++
 rtl/key_debounce.sv | 30 +++
 tb/tb_key_debounce.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding and key bit positions for the input debouncer
package key_debounce_pkg;

  // Per-bit debounce FSM state; level is 1 in HELD and RELEASE_WAIT
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Bit positions of the board inputs inside key_raw
  localparam int KEY_LOAD   = 0;
  localparam int KEY_TYPE   = 1;
  localparam int KEY_IN_LSB = 2;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - single-bit synchronizer, debounce FSM and registered strobes
module debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  // Two-flop synchronizer; only sync_q is ever looked at by the FSM
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= key_raw;
      sync_q <= meta_q;
    end
  end

  // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync_q) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!sync_q) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (sync_q) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounces the load, type and data inputs ahead of the BCD counter
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  // Every input bit gets its own independent debounce engine
  for (genvar g = 0; g < N_KEYS; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .clr        (clr),
      .key_raw    (key_raw[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce
module tb_key_debounce;

  localparam int N  = 6;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    key_raw = 6'h3F;
    repeat (3) tick();
    checks++;
    if (key_level !== 6'h00) begin errors++; $display("FAIL reset_level got %h exp %h", key_level, 6'h00); end
    checks++;
    if (key_press !== 6'h00) begin errors++; $display("FAIL reset_press got %h exp %h", key_press, 6'h00); end
    checks++;
    if (key_release !== 6'h00) begin errors++; $display("FAIL reset_release got %h exp %h", key_release, 6'h00); end
    key_raw = 6'h00;
    tick();
    clr = 1'b1;
    repeat (4) tick();
    checks++;
    if (key_level !== 6'h00) begin errors++; $display("FAIL post_reset_level got %h exp %h", key_level, 6'h00); end
  endtask

  task automatic test_clean_press();
    key_raw[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (key_level[0] !== 1'b0 || key_press[0] !== 1'b0) begin
        errors++; $display("FAIL press_early cyc %0d level %b press %b exp 0 0", i, key_level[0], key_press[0]);
      end
    end
    tick();
    checks++;
    if (key_level !== 6'h01) begin errors++; $display("FAIL press_level got %h exp %h", key_level, 6'h01); end
    checks++;
    if (key_press !== 6'h01) begin errors++; $display("FAIL press_pulse got %h exp %h", key_press, 6'h01); end
    checks++;
    if (key_release !== 6'h00) begin errors++; $display("FAIL press_release got %h exp %h", key_release, 6'h00); end
    tick();
    checks++;
    if (key_press !== 6'h00 || key_level !== 6'h01) begin
      errors++; $display("FAIL press_width press %h level %h exp 00 01", key_press, key_level);
    end
  endtask

  task automatic test_bounce();
    key_raw[0] = 1'b0;
    repeat (7) tick();
    checks++;
    if (key_release !== 6'h01 || key_level !== 6'h00) begin
      errors++; $display("FAIL bounce_prep release %h level %h exp 01 00", key_release, key_level);
    end
    repeat (2) tick();
    key_raw[0] = 1'b1; tick();
    key_raw[0] = 1'b0; tick();
    key_raw[0] = 1'b1; tick();
    key_raw[0] = 1'b0; tick();
    key_raw[0] = 1'b1;
    for (int i = 5; i <= 10; i++) begin
      tick();
      checks++;
      if (key_level[0] !== 1'b0 || key_press[0] !== 1'b0 || key_release[0] !== 1'b0) begin
        errors++; $display("FAIL bounce_quiet cyc %0d level %b press %b release %b exp 0 0 0",
                           i, key_level[0], key_press[0], key_release[0]);
      end
    end
    tick();
    checks++;
    if (key_press !== 6'h01 || key_level !== 6'h01) begin
      errors++; $display("FAIL bounce_press press %h level %h exp 01 01", key_press, key_level);
    end
    tick();
    checks++;
    if (key_press !== 6'h00) begin errors++; $display("FAIL bounce_width got %h exp %h", key_press, 6'h00); end
  endtask

  task automatic test_release();
    key_raw[2] = 1'b1;
    repeat (9) tick();
    checks++;
    if (key_level !== 6'h05) begin errors++; $display("FAIL rel_setup_level got %h exp %h", key_level, 6'h05); end
    key_raw[2] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (key_release[2] !== 1'b0 || key_level[2] !== 1'b1) begin
        errors++; $display("FAIL rel_early cyc %0d release %b level %b exp 0 1", i, key_release[2], key_level[2]);
      end
    end
    tick();
    checks++;
    if (key_release !== 6'h04 || key_level !== 6'h01) begin
      errors++; $display("FAIL rel_pulse release %h level %h exp 04 01", key_release, key_level);
    end
    tick();
    checks++;
    if (key_release !== 6'h00) begin errors++; $display("FAIL rel_width got %h exp %h", key_release, 6'h00); end

    key_raw[2] = 1'b1;
    repeat (9) tick();
    key_raw[2] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) key_raw[2] = 1'b1;
      if (i == 4) key_raw[2] = 1'b0;
      checks++;
      if (key_release[2] !== 1'b0 || key_level[2] !== 1'b1) begin
        errors++; $display("FAIL rel_glitch cyc %0d release %b level %b exp 0 1", i, key_release[2], key_level[2]);
      end
    end
    tick();
    checks++;
    if (key_release !== 6'h04 || key_level !== 6'h01) begin
      errors++; $display("FAIL rel_glitch_pulse release %h level %h exp 04 01", key_release, key_level);
    end
  endtask

  task automatic test_simultaneous();
    clr = 1'b0;
    key_raw = 6'h00;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    checks++;
    if (key_level !== 6'h00) begin errors++; $display("FAIL sim_clear got %h exp %h", key_level, 6'h00); end
    key_raw = 6'h2D;
    repeat (6) tick();
    checks++;
    if (key_press !== 6'h00 || key_level !== 6'h00) begin
      errors++; $display("FAIL sim_early press %h level %h exp 00 00", key_press, key_level);
    end
    tick();
    checks++;
    if (key_press !== 6'h2D) begin errors++; $display("FAIL sim_press got %h exp %h", key_press, 6'h2D); end
    checks++;
    if (key_level !== 6'h2D) begin errors++; $display("FAIL sim_level got %h exp %h", key_level, 6'h2D); end
    tick();
    checks++;
    if (key_press !== 6'h00 || key_release !== 6'h00) begin
      errors++; $display("FAIL sim_width press %h release %h exp 00 00", key_press, key_release);
    end
  endtask

  task automatic test_async_reset();
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (key_level !== 6'h00) begin errors++; $display("FAIL async_level got %h exp %h", key_level, 6'h00); end
    checks++;
    if (key_press !== 6'h00 || key_release !== 6'h00) begin
      errors++; $display("FAIL async_strobes press %h release %h exp 00 00", key_press, key_release);
    end
    key_raw = 6'h00;
    repeat (2) tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic test_reset_midqual();
    key_raw[1] = 1'b1;
    repeat (5) tick();
    clr = 1'b0;
    #1;
    checks++;
    if (key_level !== 6'h00 || key_press !== 6'h00) begin
      errors++; $display("FAIL midq_reset level %h press %h exp 00 00", key_level, key_press);
    end
    #2;
    clr = 1'b1;
    for (int i = 6; i <= 11; i++) begin
      tick();
      checks++;
      if (key_press[1] !== 1'b0 || key_level[1] !== 1'b0) begin
        errors++; $display("FAIL midq_early cyc %0d press %b level %b exp 0 0", i, key_press[1], key_level[1]);
      end
    end
    tick();
    checks++;
    if (key_press !== 6'h02 || key_level !== 6'h02) begin
      errors++; $display("FAIL midq_press press %h level %h exp 02 02", key_press, key_level);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (key_press !== 6'h00 || key_level !== 6'h02) begin
        errors++; $display("FAIL midq_single cyc %0d press %h level %h exp 00 02", i, key_press, key_level);
      end
    end
  endtask

  initial begin
    clr = 1'b0;
    key_raw = 6'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_async_reset();
    test_reset_midqual();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
